// File: rtl/hash_delay_pipe.sv
// Elastic delay pipeline: DELAY valid-tagged stages with backpressure,
// bubble collapse, occupancy count and synchronous flush.
module hash_delay_pipe #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DELAY      = 4,
    parameter int unsigned CNT_WIDTH  = $clog2(DELAY + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    logic [DELAY-1:0]                 v_q, v_d;
    logic [DELAY-1:0][DATA_WIDTH-1:0] d_q, d_d;
    logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
    logic [DELAY-1:0]                 rdy;
    logic                             full_run;
    logic                             in_fire, out_fire;

    // rdy[i] = ~v[i] | rdy[i+1] unrolled: a stage stalls only when it and every
    // stage downstream of it are occupied and the tail is blocked.
    always_comb begin
        rdy      = '0;
        full_run = 1'b1;
        for (int unsigned k = 0; k < DELAY; k++) begin
            full_run           = full_run & v_q[DELAY-1-k];
            rdy[DELAY-1-k]     = ready_i | ~full_run;
        end
    end

    assign ready_o  = rdy[0] & ~flush;
    assign valid_o  = v_q[DELAY-1] & ~flush;
    assign data_o   = d_q[DELAY-1];
    assign count_o  = cnt_q;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    always_comb begin
        v_d   = v_q;
        d_d   = d_q;
        cnt_d = cnt_q;

        if (rdy[0]) begin
            v_d[0] = in_fire;
            if (in_fire) begin
                d_d[0] = data_i;
            end
        end

        for (int unsigned i = 1; i < DELAY; i++) begin
            if (rdy[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end
        end

        case ({in_fire, out_fire})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase

        if (flush) begin
            v_d   = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/hash_delay_pipe.md
# hash_delay_pipe

Elastic, parametrised delay pipeline for the hash-table datapath. It replaces fixed shift-register delay lines wherever the delayed stream must tolerate downstream backpressure. Each stage carries a valid bit. Bubbles collapse, occupancy is reported, and a synchronous flush drops all in-flight entries. The block aligns key/metadata words with the multi-cycle hash and memory-lookup paths.

## Interface
- DATA_WIDTH, default 10: width of each carried word.
- DELAY, default 4: number of pipeline stages; legal range ≥ 1. This is the latency when the pipe is not stalled.
- CNT_WIDTH, default $clog2(DELAY+1): width of the occupancy count. It is derived; do not override.

- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous drop of all in-flight entries.
- valid_i, input, 1: upstream word valid.
- ready_o, output, 1: pipe can accept a word this cycle.
- data_i, input, DATA_WIDTH: upstream word.
- valid_o, output, 1: word at pipe tail is valid.
- ready_i, input, 1: downstream accepts the tail word.
- data_o, output, DATA_WIDTH: tail word.
- count_o, output, CNT_WIDTH: number of valid entries held, 0..DELAY.

## Operation
- State:
  - stages s[0..DELAY-1], each holding valid bit v[i] and data d[i];
  - occupancy counter cnt.
- Stage readiness, combinational:
  - rdy[DELAY-1] = ~v[DELAY-1] | ready_i;
  - rdy[i] = ~v[i] | rdy[i+1] for i < DELAY-1.
- Input handshake: in_fire = valid_i & ready_o. Output handshake: out_fire = valid_o & ready_i.
- Port outputs:
  - ready_o = rdy[0] & ~flush;
  - valid_o = v[DELAY-1] & ~flush;
  - data_o = d[DELAY-1].
- Stage i advances at the clock edge when rdy[i] = 1:
  - v[0] ← in_fire;
  - v[i] ← v[i-1] for i ≥ 1.
- Stage data loads only when the incoming valid is 1; otherwise d[i] holds. Data is never cleared except by reset.
- A stage with rdy[i] = 0 holds both v[i] and d[i].
- Bubble collapse: an empty stage always accepts from upstream, so a stalled tail packs entries toward it.
- count_o = cnt. Update rules:
  - +1 on in_fire only;
  - −1 on out_fire only;
  - unchanged when both or neither fire.
- Invariant: cnt always equals popcount(v).
- Flush: at the edge where flush = 1, all v[i] ← 0 and cnt ← 0.
  - No handshake can complete in a flush cycle, because ready_o and valid_o are gated low.
  - Flush takes priority over all other updates.
- Reset, asynchronous on the falling edge of reset, held while reset = 0:
  - all v[i] = 0, all d[i] = 0, cnt = 0.
  - Resulting outputs: valid_o = 0, data_o = 0, count_o = 0, ready_o = 1 (when flush = 0).
  - Reset asserted mid-stream discards all entries immediately, without waiting for a clock edge.

## Timing
- Latency: a word accepted in cycle n with no stall appears with valid_o = 1 in cycle n+DELAY. For DELAY = 1 this is one cycle.
- Throughput: one word per cycle while ready_i = 1, with no bubbles inserted.
- Full: when cnt = DELAY and ready_i = 0, ready_o = 0.
- Full pipe draining: when ready_i rises, ready_o rises in the same cycle. This is a combinational ready chain, and simultaneous accept and emit keep cnt = DELAY.
- Empty: cnt = 0, valid_o = 0, ready_o = 1.
- Combinational paths:
  - ready_i → ready_o, depth DELAY;
  - flush → ready_o and flush → valid_o.
- There is no combinational path from valid_i to any output.
- Ordering: words leave strictly in acceptance order. None is duplicated or lost, except by flush or reset.
- Deasserting reset takes effect synchronously at the next clk edge. The first word may be accepted in the first cycle after deassertion.

## Test plan
- Reset and latency (DELAY = 3, DATA_WIDTH = 8):
  - Hold reset = 0 → outputs 0/0/0 and ready_o = 1.
  - Release reset, drive 0x11, 0x22, 0x33 on consecutive cycles with ready_i = 1 → data_o shows 0x11, 0x22, 0x33 in cycles 3, 4, 5 with valid_o high; count_o peaks at 3.
- Backpressure fill:
  - Hold ready_i = 0 and stream 0xA0..0xA5 → exactly 0xA0, 0xA1, 0xA2 accepted; ready_o = 0 from the cycle after the third accept; count_o = 3.
  - Raise ready_i → 0xA0 leaves and 0xA3 is accepted in the same cycle, count_o stays 3, order is preserved.
- Bubble collapse:
  - Send 0x01 with ready_i = 0, idle two cycles, then send 0x02 → both held in s[2] and s[1], count_o = 2.
  - Release ready_i → 0x01 then 0x02 on consecutive cycles.
- Flush mid-stream:
  - With 3 entries held, pulse flush with valid_i = 1 → ready_o = 0 and valid_o = 0 during the pulse; count_o = 0 next cycle.
  - Next word 0x5A emerges exactly 3 cycles after its acceptance.
- Asynchronous reset mid-operation:
  - Assert reset between clock edges with 2 entries held → valid_o and count_o drop to 0 immediately, with no clk edge needed.
  - Data accepted after release is unaffected.
- DELAY = 1 corner:
  - Continuous stream 0x00..0x0F with random ready_i → scoreboard order matches; count_o ∈ {0, 1}; valid_o never rises in a flush cycle.
